// File: rtl/out_layer_pkg.sv
// out_layer_pkg -- shared types and helpers for the output (marginalisation) layer.
//   out_state_t : frame sequencer states
//   num_steps   : number of edge windows needed to cover e edges, e_par at a time
//   step_width  : width of a counter holding 0..num_steps-1
//   sat_to_fp   : clamp a wide signed value into the signed n_fp-bit range
package out_layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } out_state_t;

  // Widest accumulator the shared saturator handles.
  localparam int ACC_MAX_W = 32;

  function automatic int num_steps(input int e, input int e_par);
    return (e + e_par - 1) / e_par;
  endfunction

  function automatic int step_width(input int e, input int e_par);
    return (num_steps(e, e_par) > 1) ? $clog2(num_steps(e, e_par)) : 1;
  endfunction

  // Result stays ACC_MAX_W wide; callers keep the low n_fp bits.
  function automatic logic signed [ACC_MAX_W-1:0] sat_to_fp(
    input logic signed [ACC_MAX_W-1:0] acc,
    input int                          n_fp
  );
    logic signed [ACC_MAX_W-1:0] hi;
    logic signed [ACC_MAX_W-1:0] lo;
    hi = (32'sd1 <<< (n_fp - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (n_fp - 1));
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/out_layer_serial_if.sv
// out_layer_serial_if -- frame handshake bundle of the output layer.
//   in_valid/in_ready       : input frame handshake (llr, prev_proc_elem)
//   out_valid/out_ready     : result handshake (out_llr, out_hard, sat_flag)
//   sat_flag exists only when OUT_LAYER_SAT_FLAG_EN is defined.
//   master : upstream/downstream side, slave : the layer itself.
interface out_layer_serial_if #(
  parameter int N_V  = 44,
  parameter int E    = 147,
  parameter int N_FP = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_V-1:0][N_FP-1:0]  llr;
  logic [E-1:0][N_FP-1:0]    prev_proc_elem;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_V-1:0][N_FP-1:0]  out_llr;
  logic [N_V-1:0]            out_hard;
`ifdef OUT_LAYER_SAT_FLAG_EN
  logic [N_V-1:0]            sat_flag;
`endif

  modport master (
`ifdef OUT_LAYER_SAT_FLAG_EN
    input  sat_flag,
`endif
    output in_valid, llr, prev_proc_elem, out_ready,
    input  in_ready, out_valid, out_llr, out_hard
  );

  modport slave (
`ifdef OUT_LAYER_SAT_FLAG_EN
    output sat_flag,
`endif
    input  in_valid, llr, prev_proc_elem, out_ready,
    output in_ready, out_valid, out_llr, out_hard
  );

endinterface

// File: rtl/out_layer_acc_lane.sv
// out_layer_acc_lane -- one variable-node accumulator of the output layer.
//   load     : start of frame, acc <= sext(llr_in)
//   accum_en : add the masked E_PAR-message window into acc
//   capture  : last window; register saturated result, hard bit (and sat flag)
//   win/mask : current message window and this node's incidence bits for it
//   out_llr/out_hard/sat : registered results, held until the next capture
//   sat port exists only when OUT_LAYER_SAT_FLAG_EN is defined.
module out_layer_acc_lane
  import out_layer_pkg::*;
#(
  parameter int N_FP  = 8,
  parameter int E_PAR = 8,
  parameter int N_ACC = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        accum_en,
  input  logic                        capture,
  input  logic [N_FP-1:0]             llr_in,
  input  logic [E_PAR-1:0][N_FP-1:0]  win,
  input  logic [E_PAR-1:0]            mask,
`ifdef OUT_LAYER_SAT_FLAG_EN
  output logic                        sat,
`endif
  output logic [N_FP-1:0]             out_llr,
  output logic                        out_hard
);

  localparam int W = ACC_MAX_W;

  logic [N_ACC-1:0]     acc;
  logic [N_ACC-1:0]     acc_next;
  logic signed [W-1:0]  sum_w;
  logic signed [W-1:0]  next_w;
  logic signed [W-1:0]  clamp_w;

  // Masked adder tree over the window, evaluated wide so overflow is observable.
  always_comb begin
    sum_w = '0;
    for (int k = 0; k < E_PAR; k++) begin
      if (mask[k]) begin
        sum_w = sum_w + W'($signed(win[k]));
      end else begin
        sum_w = sum_w;
      end
    end
    next_w   = W'($signed(acc)) + sum_w;
    acc_next = next_w[N_ACC-1:0];
    clamp_w  = sat_to_fp(W'($signed(acc_next)), N_FP);
  end

  // Accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      out_llr  <= '0;
      out_hard <= 1'b0;
`ifdef OUT_LAYER_SAT_FLAG_EN
      sat      <= 1'b0;
`endif
    end else begin
      if (load) begin
        acc <= N_ACC'($signed(llr_in));
      end else if (accum_en) begin
        acc <= acc_next;
      end
      if (capture) begin
        out_llr  <= clamp_w[N_FP-1:0];
        out_hard <= clamp_w[N_FP-1];
`ifdef OUT_LAYER_SAT_FLAG_EN
        sat      <= (clamp_w != W'($signed(acc_next)));
`endif
      end
    end
  end

  // N_ACC too narrow for the node degree makes the accumulator wrap.
  a_acc_no_wrap: assert property (@(posedge clk) disable iff (rst)
    accum_en |-> (next_w == W'($signed(acc_next))));

  a_clamp_fits: assert property (@(posedge clk) disable iff (rst)
    capture |-> (clamp_w == W'($signed(clamp_w[N_FP-1:0]))));

endmodule

// File: rtl/out_layer_serial.sv
// out_layer_serial -- time-multiplexed output (marginalisation) layer.
//   out_llr[i] = sat(llr[i] + sum of prev_proc_elem[e] over edges with adj_matrix[i][e]).
//   Edges are walked E_PAR per cycle over S = ceil(E/E_PAR) ACCUM cycles;
//   results appear S+1 cycles after the input handshake and are held until taken.
//   clk, rst          : clock, synchronous active-high reset
//   adj_matrix        : VN-to-edge incidence, must not change outside IDLE
//   bus (slave)       : in_valid/in_ready/llr/prev_proc_elem,
//                       out_valid/out_ready/out_llr/out_hard[/sat_flag]
//   Optional: OUT_LAYER_SAT_FLAG_EN adds sat_flag (clamp changed the value).
module out_layer_serial
  import out_layer_pkg::*;
#(
  parameter int N_V   = 44,
  parameter int N_C   = 12,
  parameter int E     = 147,
  parameter int N_FP  = 8,
  parameter int E_PAR = 8,
  parameter int N_ACC = N_FP + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_V-1:0][E-1:0]  adj_matrix,
  out_layer_serial_if.slave      bus
);

  localparam int S  = num_steps(E, E_PAR);
  localparam int SW = step_width(E, E_PAR);
  localparam int EP = S * E_PAR;

  if (N_ACC < N_FP + 1 || N_ACC > ACC_MAX_W || E_PAR < 1 || E_PAR > E || N_C < 1) begin : g_bad_cfg
    $error("out_layer_serial: illegal parameter set");
  end

  out_state_t                state;
  logic [SW-1:0]             step;
  logic [E-1:0][N_FP-1:0]    msg;
  logic                      in_rdy;
  logic                      out_vld;
  logic                      last_step;
  logic                      load;
  logic                      accum_en;
  logic                      capture;
  logic [EP-1:0][N_FP-1:0]   msg_pad;
  logic [E_PAR-1:0][N_FP-1:0] win;
  logic [N_V-1:0][N_FP-1:0]  lane_llr;
  logic [N_V-1:0]            lane_hard;

  assign last_step = (step == SW'(S - 1));
  assign load      = (state == IDLE) && bus.in_valid;
  assign accum_en  = (state == ACCUM);
  assign capture   = accum_en && last_step;

  // Message window for the current step; padding past E reads as zero.
  always_comb begin
    msg_pad        = '0;
    msg_pad[E-1:0] = msg;
    win            = '0;
    for (int s = 0; s < S; s++) begin
      if (step == SW'(s)) begin
        win = msg_pad[s*E_PAR +: E_PAR];
      end else begin
        win = win;
      end
    end
  end

  // Frame sequencing: accept, walk the edge windows, hold results until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      msg     <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            msg    <= bus.prev_proc_elem;
            step   <= '0;
            in_rdy <= 1'b0;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (last_step) begin
            step    <= '0;
            out_vld <= 1'b1;
            state   <= DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          step    <= '0;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_V; i++) begin : g_lane
    logic [EP-1:0]    adj_pad;
    logic [E_PAR-1:0] mask;

    // This node's incidence bits for the current window; padded edges are unconnected.
    always_comb begin
      adj_pad        = '0;
      adj_pad[E-1:0] = adj_matrix[i];
      mask           = '0;
      for (int s = 0; s < S; s++) begin
        if (step == SW'(s)) begin
          mask = adj_pad[s*E_PAR +: E_PAR];
        end else begin
          mask = mask;
        end
      end
    end

    out_layer_acc_lane #(
      .N_FP  (N_FP),
      .E_PAR (E_PAR),
      .N_ACC (N_ACC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .accum_en (accum_en),
      .capture  (capture),
      .llr_in   (bus.llr[i]),
      .win      (win),
      .mask     (mask),
`ifdef OUT_LAYER_SAT_FLAG_EN
      .sat      (bus.sat_flag[i]),
`endif
      .out_llr  (lane_llr[i]),
      .out_hard (lane_hard[i])
    );
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_llr   = lane_llr;
  assign bus.out_hard  = lane_hard;

  // The incidence matrix is read live every ACCUM cycle, so it must hold still.
  a_adj_stable: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> $stable(adj_matrix));

endmodule

// File: tb/tb_out_layer_serial.sv
// Directed bench for out_layer_serial (N_V=4, E=6, N_FP=8, N_ACC=12).
// Main DUT uses E_PAR=4 (S=2); two extra instances use E_PAR=1 and E_PAR=E.
module tb_out_layer_serial;

  localparam int N_V  = 4;
  localparam int E    = 6;
  localparam int N_FP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_V-1:0][E-1:0] adj;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  out_layer_serial_if #(.N_V(N_V), .E(E), .N_FP(N_FP)) bus0 ();
  out_layer_serial_if #(.N_V(N_V), .E(E), .N_FP(N_FP)) bus1 ();
  out_layer_serial_if #(.N_V(N_V), .E(E), .N_FP(N_FP)) bus2 ();

  assign bus1.llr            = bus0.llr;
  assign bus1.prev_proc_elem = bus0.prev_proc_elem;
  assign bus2.llr            = bus0.llr;
  assign bus2.prev_proc_elem = bus0.prev_proc_elem;

  out_layer_serial #(.N_V(N_V), .N_C(3), .E(E), .N_FP(N_FP), .E_PAR(4), .N_ACC(12))
    dut (.clk(clk), .rst(rst), .adj_matrix(adj), .bus(bus0));
  out_layer_serial #(.N_V(N_V), .N_C(3), .E(E), .N_FP(N_FP), .E_PAR(1), .N_ACC(12))
    dut_p1 (.clk(clk), .rst(rst), .adj_matrix(adj), .bus(bus1));
  out_layer_serial #(.N_V(N_V), .N_C(3), .E(E), .N_FP(N_FP), .E_PAR(E), .N_ACC(12))
    dut_pe (.clk(clk), .rst(rst), .adj_matrix(adj), .bus(bus2));

  always #5 clk = ~clk;

  // Stimulus vectors and hand-computed results.
  int v1_l  [N_V] = '{10, -3, 0, 5};
  int v1_m  [E]   = '{1, 2, 3, 4, 5, -6};
  int v1_x  [N_V] = '{13, 0, 9, -1};
  int sp_l  [N_V] = '{100, -3, 0, 5};
  int sp_m  [E]   = '{100, 100, 3, 4, 5, -6};
  int sp_x  [N_V] = '{127, 0, 9, -1};
  int sn_l  [N_V] = '{-100, -3, 0, 5};
  int sn_m  [E]   = '{-100, -100, 3, 4, 5, -6};
  int sn_x  [N_V] = '{-128, 0, 9, -1};
  int b_l   [N_V] = '{-20, 7, 1, -2};
  int b_m   [E]   = '{5, -5, 10, -10, 20, 30};
  int b_x   [N_V] = '{-20, 17, 11, 28};
  int c_x   [N_V] = '{15, 2, 21, -2};
  int zero_x[N_V] = '{0, 0, 0, 0};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_vld(input int which);
    case (which)
      0:       return bus0.out_valid;
      1:       return bus1.out_valid;
      default: return bus2.out_valid;
    endcase
  endfunction

  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (!get_vld(which) && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("wait_valid%0d", which), get_vld(which), 1);
  endtask

  task automatic chk_out(input string tag, input int which, input int exp [N_V]);
    logic [N_V-1:0][N_FP-1:0] o;
    logic [N_V-1:0]           h;
    case (which)
      0:       begin o = bus0.out_llr; h = bus0.out_hard; end
      1:       begin o = bus1.out_llr; h = bus1.out_hard; end
      default: begin o = bus2.out_llr; h = bus2.out_hard; end
    endcase
    for (int i = 0; i < N_V; i++) begin
      chk($sformatf("%s_llr%0d", tag, i), $signed(o[i]), exp[i]);
      chk($sformatf("%s_hard%0d", tag, i), h[i], (exp[i] < 0) ? 1 : 0);
    end
  endtask

  task automatic set_data(input int l [N_V], input int m [E]);
    for (int i = 0; i < N_V; i++) bus0.llr[i] = 8'(l[i]);
    for (int k = 0; k < E; k++) bus0.prev_proc_elem[k] = 8'(m[k]);
  endtask

  task automatic run_main(input string tag, input int l [N_V], input int m [E], input int exp [N_V]);
    int n;
    set_data(l, m);
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    chk({tag, "_in_ready"}, bus0.in_ready, 1);
    tick();
    bus0.in_valid = 1'b0;
    wait_valid(0, n);
    chk({tag, "_latency"}, n, 2);
    chk_out(tag, 0, exp);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, bus0.out_valid, 0);
    chk({tag, "_rdy_back"}, bus0.in_ready, 1);
  endtask

  initial begin
    int n;
    int t_a;
    adj[0] = 6'b000011;
    adj[1] = 6'b000100;
    adj[2] = 6'b011000;
    adj[3] = 6'b100000;
    set_data(v1_l, v1_m);
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_out_valid", bus0.out_valid, 0);
    chk_out("rst", 0, zero_x);
    rst = 1'b0;

    // Basic frame, then 5-cycle out_ready stall with in_valid asserted
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    chk("v1_busy_in_ready", bus0.in_ready, 0);
    wait_valid(0, n);
    chk("v1_latency", n, 2);
    chk_out("v1", 0, v1_x);
    for (int c = 0; c < 5; c++) begin
      set_data(sp_l, sp_m);
      bus0.in_valid = 1'b1;
      tick();
      chk($sformatf("stall%0d_vld", c), bus0.out_valid, 1);
      chk($sformatf("stall%0d_rdy", c), bus0.in_ready, 0);
      chk_out($sformatf("stall%0d", c), 0, v1_x);
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk("hs_vld_drop", bus0.out_valid, 0);
    chk("hs_rdy_back", bus0.in_ready, 1);
    chk_out("hs_hold", 0, v1_x);
    tick();
    chk("hs_no_frame", bus0.out_valid, 0);

    // Saturation both ways
    run_main("satp", sp_l, sp_m, sp_x);
`ifdef OUT_LAYER_SAT_FLAG_EN
    chk("satp_flag", bus0.sat_flag, 4'b0001);
`endif
    run_main("satn", sn_l, sn_m, sn_x);
`ifdef OUT_LAYER_SAT_FLAG_EN
    chk("satn_flag", bus0.sat_flag, 4'b0001);
`endif

    // Different incidence pattern, including a node with no edges
    adj[0] = 6'b100001;
    adj[1] = 6'b001110;
    adj[2] = 6'b010000;
    adj[3] = 6'b000000;
    run_main("alt", b_l, b_m, c_x);
`ifdef OUT_LAYER_SAT_FLAG_EN
    chk("alt_flag", bus0.sat_flag, 4'b0000);
`endif

    // Reset in the first ACCUM cycle
    adj[0] = 6'b000011;
    adj[1] = 6'b000100;
    adj[2] = 6'b011000;
    adj[3] = 6'b100000;
    set_data(v1_l, v1_m);
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", bus0.out_valid, 0);
    chk("mid_rst_rdy", bus0.in_ready, 1);
    chk_out("mid_rst", 0, zero_x);
    tick();
    tick();
    tick();
    chk("mid_rst_discard", bus0.out_valid, 0);
    run_main("after_rst", v1_l, v1_m, v1_x);

    // Back-to-back frames with out_ready held high
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    set_data(v1_l, v1_m);
    tick();
    set_data(b_l, b_m);
    wait_valid(0, n);
    chk("b2b_a_latency", n, 2);
    t_a = cyc;
    chk_out("b2b_a", 0, v1_x);
    tick();
    chk("b2b_gap_vld", bus0.out_valid, 0);
    chk("b2b_gap_rdy", bus0.in_ready, 1);
    tick();
    bus0.in_valid = 1'b0;
    wait_valid(0, n);
    chk("b2b_period", cyc - t_a, 4);
    chk_out("b2b_b", 0, b_x);
    tick();
    chk("b2b_end_vld", bus0.out_valid, 0);
    bus0.out_ready = 1'b0;

    // E_PAR=1 and E_PAR=E builds on the basic vector
    set_data(v1_l, v1_m);
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    wait_valid(1, n);
    chk("ep1_latency", n, 6);
    chk_out("ep1", 1, v1_x);
    tick();
    chk("ep1_vld_drop", bus1.out_valid, 0);

    bus2.in_valid = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    wait_valid(2, n);
    chk("epe_latency", n, 1);
    chk_out("epe", 2, v1_x);
    tick();
    chk("epe_vld_drop", bus2.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
